// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared mode encoding and counter limits for the clock adjust logic
// Purpose: mode/state encoding and sec/min maximum used by the controller and its bench.
// Ports: none (package).
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'b00,
    MODE_ADJ_HOUR = 2'b01,
    MODE_ADJ_MIN  = 2'b10
  } mode_e;

  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic [5:0] MIN_MAX = 6'd59;

endpackage

// File: rtl/adj_timeout_timer.sv
// rtl/adj_timeout_timer.sv - idle-tick counter that expires an adjust mode
// Purpose: counts 1 Hz ticks while an adjust mode is idle and flags the tick that
//          reaches TIMEOUT_TICKS.
// Ports:
//   clk, reset  - system clock, asynchronous active-high reset
//   active      - high while in an adjust mode; counter is held at 0 otherwise
//   clear       - user activity or mode change restarts the idle count
//   tick        - 1 Hz pulse
//   expire      - combinational: this tick is the TIMEOUT_TICKS-th idle tick
module adj_timeout_timer #(
  parameter int TIMEOUT_TICKS = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic clear,
  input  logic tick,
  output logic expire
);

  localparam int W = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_TICKS - 1);

  logic [W-1:0] count;

  // Activity in the same cycle as the final tick wins: the idle run is broken.
  assign expire = active && !clear && tick && (count == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!active || clear) begin
      count <= '0;
    end else if (tick) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/time_adjust_controller.sv
// rtl/time_adjust_controller.sv - run/adjust control for external sec/min/hour counters
// Purpose: advances the time on each 1 Hz tick in RUN and lets the user step hours or
//          minutes up/down in the adjust modes, with an idle timeout back to RUN.
// Ports:
//   clk, reset                      - system clock, asynchronous active-high reset
//   tick_1hz                        - one-cycle pulse per second
//   btn_mode, btn_up, btn_down      - debounced one-cycle button pulses
//   sec_count, min_count, hour_count- current external counter values
//   sec_inc, min_inc, hour_inc      - registered one-cycle increment pulses
//   min_updown, hour_updown         - registered count direction (1 = up), held
//   sec_clr                         - registered pulse clearing seconds on leaving ADJ_MIN
//   mode                            - 00 RUN, 01 ADJ_HOUR, 10 ADJ_MIN
//   blink                           - blank phase of the field under adjustment
module time_adjust_controller
  import clock_pkg::*;
#(
  parameter int TIMEOUT_TICKS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [5:0] sec_count,
  input  logic [5:0] min_count,
  input  logic [4:0] hour_count,
  output logic       sec_inc,
  output logic       min_inc,
  output logic       hour_inc,
  output logic       min_updown,
  output logic       hour_updown,
  output logic       sec_clr,
  output logic [1:0] mode,
  output logic       blink
);

  mode_e state, state_d;
  logic  sec_inc_d, min_inc_d, hour_inc_d;
  logic  min_updown_d, hour_updown_d, sec_clr_d, blink_d;
  logic  adjusting, accepted, expire;

  // Hour rollover is handled by the external counter itself.
  logic  unused_hour;
  assign unused_hour = ^hour_count;

  assign adjusting = (state != MODE_RUN);
  // Up and down together is ambiguous and is dropped.
  assign accepted  = adjusting && (btn_up ^ btn_down);
  assign mode      = state;

  adj_timeout_timer #(
    .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) u_timeout (
    .clk   (clk),
    .reset (reset),
    .active(adjusting),
    .clear (accepted || btn_mode),
    .tick  (tick_1hz),
    .expire(expire)
  );

  always_comb begin
    state_d       = state;
    sec_inc_d     = 1'b0;
    min_inc_d     = 1'b0;
    hour_inc_d    = 1'b0;
    min_updown_d  = min_updown;
    hour_updown_d = hour_updown;
    sec_clr_d     = 1'b0;
    blink_d       = blink;

    // btn_mode masks expire inside the timer, so at most one step is taken.
    case (state)
      MODE_RUN:      if (btn_mode) state_d = MODE_ADJ_HOUR;
      MODE_ADJ_HOUR: begin
        if (btn_mode)    state_d = MODE_ADJ_MIN;
        else if (expire) state_d = MODE_RUN;
      end
      MODE_ADJ_MIN:  if (btn_mode || expire) state_d = MODE_RUN;
      default:       state_d = MODE_RUN;
    endcase

    if (state == MODE_RUN && tick_1hz) begin
      sec_inc_d = 1'b1;
      if (sec_count == SEC_MAX) begin
        min_inc_d    = 1'b1;
        min_updown_d = 1'b1;
        if (min_count == MIN_MAX) begin
          hour_inc_d    = 1'b1;
          hour_updown_d = 1'b1;
        end
      end
    end

    if (accepted) begin
      if (state == MODE_ADJ_HOUR) begin
        hour_inc_d    = 1'b1;
        hour_updown_d = btn_up;
      end else begin
        min_inc_d    = 1'b1;
        min_updown_d = btn_up;
      end
    end

    sec_clr_d = (state == MODE_ADJ_MIN) && (state_d == MODE_RUN);

    if (state_d != state || !adjusting) blink_d = 1'b0;
    else if (tick_1hz)                  blink_d = ~blink;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= MODE_RUN;
      sec_inc     <= 1'b0;
      min_inc     <= 1'b0;
      hour_inc    <= 1'b0;
      min_updown  <= 1'b1;
      hour_updown <= 1'b1;
      sec_clr     <= 1'b0;
      blink       <= 1'b0;
    end else begin
      state       <= state_d;
      sec_inc     <= sec_inc_d;
      min_inc     <= min_inc_d;
      hour_inc    <= hour_inc_d;
      min_updown  <= min_updown_d;
      hour_updown <= hour_updown_d;
      sec_clr     <= sec_clr_d;
      blink       <= blink_d;
    end
  end

endmodule

// File: tb/tb_time_adjust_controller.sv
// tb/tb_time_adjust_controller.sv - self-checking bench for time_adjust_controller
module tb_time_adjust_controller;

  localparam int TO = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_1hz = 1'b0, btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic [5:0] sec_count = '0, min_count = '0;
  logic [4:0] hour_count = '0;
  logic       sec_inc, min_inc, hour_inc, min_updown, hour_updown, sec_clr, blink;
  logic [1:0] mode;

  int checks = 0;
  int failures = 0;

  // reference model state
  int   m_mode, m_idle;
  logic m_blink, m_mud, m_hud;
  logic e_sec_inc, e_min_inc, e_hour_inc, e_sec_clr;

  time_adjust_controller #(.TIMEOUT_TICKS(TO)) dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .btn_mode(btn_mode),
    .btn_up(btn_up), .btn_down(btn_down), .sec_count(sec_count),
    .min_count(min_count), .hour_count(hour_count), .sec_inc(sec_inc),
    .min_inc(min_inc), .hour_inc(hour_inc), .min_updown(min_updown),
    .hour_updown(hour_updown), .sec_clr(sec_clr), .mode(mode), .blink(blink)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_mode = 0; m_idle = 0; m_blink = 0; m_mud = 1; m_hud = 1;
    e_sec_inc = 0; e_min_inc = 0; e_hour_inc = 0; e_sec_clr = 0;
  endfunction

  function automatic void model_step(input logic t, bm, up, dn, input logic [5:0] s, m);
    bit adj, one, timeout;
    int nm;
    adj = (m_mode != 0);
    one = (up != dn);
    e_sec_inc  = (m_mode == 0) && t;
    e_min_inc  = e_sec_inc && (s == 59);
    e_hour_inc = e_min_inc && (m == 59);
    if (e_min_inc)  m_mud = 1;
    if (e_hour_inc) m_hud = 1;
    if (adj && one) begin
      if (m_mode == 1) begin e_hour_inc = 1; m_hud = up; end
      else             begin e_min_inc  = 1; m_mud = up; end
    end
    if (adj) begin
      if (one || bm) m_idle = 0;
      else if (t)    m_idle = m_idle + 1;
    end
    timeout = adj && (m_idle >= TO);
    nm = bm ? (m_mode + 1) % 3 : (timeout ? 0 : m_mode);
    e_sec_clr = (m_mode == 2) && (nm == 0);
    if (nm != m_mode || nm == 0) m_blink = 0;
    else if (t)                  m_blink = !m_blink;
    if (nm != m_mode) m_idle = 0;
    m_mode = nm;
  endfunction

  task automatic drive(input logic t, bm, up, dn, input logic [5:0] s, m);
    @(negedge clk);
    tick_1hz = t; btn_mode = bm; btn_up = up; btn_down = dn;
    sec_count = s; min_count = m;
    model_step(t, bm, up, dn, s, m);
    @(posedge clk);
    #1;
    tick_1hz = 0; btn_mode = 0; btn_up = 0; btn_down = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    model_reset();
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1;
    #1;
    checks++;
    if ({mode, sec_inc, min_inc, hour_inc, sec_clr, blink, min_updown, hour_updown} !== 9'b00_00000_11) begin
      failures++;
      $display("FAIL reset_state got=%b want=%b",
               {mode, sec_inc, min_inc, hour_inc, sec_clr, blink, min_updown, hour_updown}, 9'b00_00000_11);
    end
    model_reset();
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_run_carry();
    do_reset();
    drive(1, 0, 0, 0, 6'd59, 6'd10);
    checks++;
    if ({sec_inc, min_inc, min_updown, hour_inc} !== 4'b1110) begin
      failures++; $display("FAIL run_carry_min got=%b want=1110", {sec_inc, min_inc, min_updown, hour_inc});
    end
    drive(1, 0, 0, 0, 6'd59, 6'd59);
    checks++;
    if ({sec_inc, min_inc, hour_inc, hour_updown} !== 4'b1111) begin
      failures++; $display("FAIL run_carry_hour got=%b want=1111", {sec_inc, min_inc, hour_inc, hour_updown});
    end
    drive(1, 0, 0, 0, 6'd30, 6'd59);
    checks++;
    if ({sec_inc, min_inc, hour_inc} !== 3'b100) begin
      failures++; $display("FAIL run_tick_plain got=%b want=100", {sec_inc, min_inc, hour_inc});
    end
    drive(0, 0, 1, 0, 6'd59, 6'd59);
    checks++;
    if ({sec_inc, min_inc, hour_inc, mode} !== 5'b000_00) begin
      failures++; $display("FAIL run_ignores_up got=%b want=00000", {sec_inc, min_inc, hour_inc, mode});
    end
  endtask

  task automatic test_adjust_hour();
    do_reset();
    drive(0, 1, 0, 0, 0, 0);
    checks++;
    if (mode !== 2'b01) begin failures++; $display("FAIL adj_hour_entry mode=%b want=01", mode); end
    drive(0, 0, 0, 1, 0, 0);
    checks++;
    if ({hour_inc, hour_updown, min_inc} !== 3'b100) begin
      failures++; $display("FAIL adj_hour_down got=%b want=100", {hour_inc, hour_updown, min_inc});
    end
    drive(0, 0, 1, 1, 0, 0);
    checks++;
    if ({hour_inc, hour_updown} !== 2'b00) begin
      failures++; $display("FAIL adj_hour_both got=%b want=00", {hour_inc, hour_updown});
    end
    drive(0, 0, 1, 0, 0, 0);
    checks++;
    if ({hour_inc, hour_updown} !== 2'b11) begin
      failures++; $display("FAIL adj_hour_up got=%b want=11", {hour_inc, hour_updown});
    end
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    checks++;
    if ({mode, sec_clr} !== 3'b00_1) begin
      failures++; $display("FAIL adj_btn_exit got=%b want=001", {mode, sec_clr});
    end
  endtask

  task automatic test_timeout();
    int mi, sc, si;
    do_reset();
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    checks++;
    if (mode !== 2'b10) begin failures++; $display("FAIL to_entry mode=%b want=10", mode); end
    drive(0, 0, 1, 0, 0, 0);
    mi = int'(min_inc); sc = 0; si = 0;
    for (int i = 1; i <= TO; i++) begin
      drive(1, 0, 0, 0, 6'd59, 6'd59);
      mi += int'(min_inc); sc += int'(sec_clr); si += int'(sec_inc);
      if (i == 1) begin
        checks++;
        if (blink !== 1'b1) begin failures++; $display("FAIL to_blink_toggle blink=%b want=1", blink); end
      end
      if (i == TO - 1) begin
        checks++;
        if (mode !== 2'b10) begin failures++; $display("FAIL to_early mode=%b want=10", mode); end
      end
    end
    checks++;
    if ({mode, blink} !== 3'b00_0) begin
      failures++; $display("FAIL to_return got=%b want=000", {mode, blink});
    end
    drive(0, 0, 0, 0, 0, 0);
    sc += int'(sec_clr);
    checks++;
    if (mi != 1 || sc != 1 || si != 0) begin
      failures++; $display("FAIL to_pulse_counts min_inc=%0d sec_clr=%0d sec_inc=%0d want 1 1 0", mi, sc, si);
    end
  endtask

  task automatic test_reset_mid_adjust();
    int sc;
    do_reset();
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 6'd59, 6'd59);
    checks++;
    if (sec_inc !== 1'b0) begin failures++; $display("FAIL adj_min_frozen sec_inc=%b want=0", sec_inc); end
    #2 reset = 1;
    #1;
    checks++;
    if (mode !== 2'b00) begin failures++; $display("FAIL mid_reset_mode mode=%b want=00", mode); end
    sc = int'(sec_clr);
    model_reset();
    @(negedge clk);
    sc += int'(sec_clr);
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      sc += int'(sec_clr);
    end
    checks++;
    if (sc != 0) begin failures++; $display("FAIL mid_reset_sec_clr count=%0d want=0", sc); end
  endtask

  task automatic test_mode_timeout_coincide();
    do_reset();
    drive(0, 1, 0, 0, 0, 0);
    for (int i = 1; i < TO; i++) drive(1, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0);
    checks++;
    if ({mode, sec_clr} !== 3'b10_0) begin
      failures++; $display("FAIL coincide_step got=%b want=100", {mode, sec_clr});
    end
    drive(1, 0, 0, 0, 0, 0);
    checks++;
    if (mode !== 2'b10) begin failures++; $display("FAIL coincide_settle mode=%b want=10", mode); end
  endtask

  task automatic test_random();
    logic [8:0] got, want;
    logic [5:0] s, m;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      s = ($urandom_range(0, 2) == 0) ? 6'd59 : 6'($urandom_range(0, 58));
      m = ($urandom_range(0, 2) == 0) ? 6'd59 : 6'($urandom_range(0, 58));
      drive($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, s, m);
      got  = {mode, sec_inc, min_inc, hour_inc, sec_clr, blink, min_updown, hour_updown};
      want = {2'(m_mode), e_sec_inc, e_min_inc, e_hour_inc, e_sec_clr, m_blink, m_mud, m_hud};
      checks++;
      if (got !== want) begin
        failures++; $display("FAIL random_cycle%0d got=%b want=%b", i, got, want);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_run_carry();
    test_adjust_hour();
    test_timeout();
    test_reset_mid_adjust();
    test_mode_timeout_coincide();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/time_adjust_controller.md
TIME_ADJUST_CONTROLLER -- requirements
Module: time_adjust_controller

Interface
REQ-001 SHALL have parameter TIMEOUT_TICKS, default 10, the number of idle 1 Hz ticks in an adjust mode before auto-return to RUN.
REQ-002 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port tick_1hz, input, 1, a one-cycle pulse once per second.
REQ-005 SHALL have port btn_mode, input, 1, a one-cycle debounced pulse.
REQ-006 SHALL have ports btn_up and btn_down, inputs, 1 each, one-cycle debounced pulses.
REQ-007 SHALL have ports sec_count (6), min_count (6) and hour_count (5), inputs, the current values of the external counters.
REQ-008 SHALL have ports sec_inc, min_inc and hour_inc, outputs, 1 each, drive the counter Inc inputs, one-cycle pulses.
REQ-009 SHALL have ports min_updown and hour_updown, outputs, 1 each, drive counter UpDown inputs (1 = up, 0 = down).
REQ-010 SHALL have port sec_clr, output, 1, a one-cycle pulse that synchronously clears the seconds counter.
REQ-011 SHALL have port mode, output, 2, encoding 00 = RUN, 01 = ADJ_HOUR, 10 = ADJ_MIN.
REQ-012 SHALL have port blink, output, 1, the display blank phase for the field under adjustment.

Function
REQ-013 SHALL register all outputs; each response appears exactly one clk after the input that causes it.
REQ-014 FSM states SHALL be RUN, ADJ_HOUR and ADJ_MIN; btn_mode SHALL advance RUN->ADJ_HOUR->ADJ_MIN->RUN.
REQ-015 In RUN, tick_1hz SHALL produce sec_inc.
- If sec_count==59 in the same cycle, it SHALL also produce min_inc with min_updown=1.
- If additionally min_count==59, it SHALL also produce hour_inc with hour_updown=1.
REQ-016 In RUN, btn_up and btn_down SHALL be ignored.
REQ-017 In ADJ_HOUR, btn_up SHALL produce hour_inc with hour_updown=1, and btn_down SHALL produce hour_inc with hour_updown=0.
REQ-018 In ADJ_MIN, up/down SHALL act on min_inc/min_updown in the same way; min SHALL NOT carry into hour.
REQ-019 btn_up and btn_down asserted in the same cycle SHALL be ignored, with no inc pulse.
REQ-020 In either adjust state, tick_1hz SHALL NOT produce any inc pulse; seconds are frozen.
REQ-021 The transition ADJ_MIN->RUN, by button or timeout, SHALL pulse sec_clr once.
REQ-022 Timeout counter:
- cleared on entry to any adjust state and on any accepted up/down;
- incremented on tick_1hz;
- reaching TIMEOUT_TICKS SHALL force RUN.
REQ-023 btn_mode and a timeout in the same cycle SHALL produce a single transition to the next state, never a double step.
REQ-024 A button and tick_1hz in the same cycle SHALL both be processed according to the current state.
REQ-025 blink SHALL toggle on each tick_1hz in the adjust states, SHALL be 0 in RUN, and SHALL be forced to 0 on every state change.
REQ-026 min_updown and hour_updown SHALL hold their last value between pulses.

Reset
REQ-027 reset SHALL immediately force:
- state RUN, mode=00;
- all inc pulses, sec_clr and blink to 0;
- min_updown and hour_updown to 1;
- timeout counter to 0.
REQ-028 Reset asserted mid-adjust SHALL abandon the adjust without a sec_clr pulse.

Structure
REQ-029 The mode/state encoding and the constants 59 (sec/min maximum) SHALL reside in the shared package clock_pkg.
REQ-030 The timeout counter SHALL be the sub-module adj_timeout_timer, parameterized by TIMEOUT_TICKS.

Verification
REQ-031 Reset, RUN, sec_count=59, min_count=10, tick -> one cycle later: sec_inc=1, min_inc=1, min_updown=1, hour_inc=0.
REQ-032 RUN, sec=59, min=59, tick -> sec_inc, min_inc and hour_inc all 1 in the same cycle.
REQ-033 btn_mode, then btn_down -> mode=01, then hour_inc=1 with hour_updown=0; up and down together -> no pulse.
REQ-034 btn_mode x2, btn_up, 10 ticks with no button -> min_inc once, mode returns to 00 after the 10th tick, sec_clr pulses once, blink=0.
REQ-035 ADJ_MIN, tick -> no sec_inc; reset mid-ADJ_MIN -> mode=00, sec_clr never pulses.
REQ-036 ADJ_HOUR with btn_mode coincident with the 10th idle tick -> mode=10 only.
